// File: rtl/bitserial_nn_pkg.sv
// Shared types and address-width helpers for the bit-serial NN engine blocks.
// Every weight-memory index is at least one bit wide, even for a dimension of one.
package bitserial_nn_pkg;

  localparam int WMEM_N_IN     = 128;
  localparam int WMEM_N_HIDDEN = 64;
  localparam int WMEM_N_LAYERS = 3;

  function automatic int addr_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

  localparam int WMEM_L_W = addr_w(WMEM_N_LAYERS);
  localparam int WMEM_H_W = addr_w(WMEM_N_HIDDEN);
  localparam int WMEM_I_W = addr_w(WMEM_N_IN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/wmem_stream_loader_if.sv
// Weight stream in, weight-memory write port out, bundled for the loader.
// Handshake: a beat transfers on a rising edge where s_axis_tvalid && s_axis_tready;
// tready never depends on tvalid, and the source holds tdata/tlast until it transfers.
interface wmem_stream_loader_if #(
  parameter int DATA_W = 16,
  parameter int L_W    = 2,
  parameter int H_W    = 6,
  parameter int I_W    = 7
);
  logic [DATA_W-1:0]        s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic                     s_axis_tlast;

  logic                     w_wr_en;
  logic [L_W-1:0]           w_addr_l;
  logic [H_W-1:0]           w_addr_h;
  logic [I_W-1:0]           w_addr_i;
  logic signed [DATA_W-1:0] w_data;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data
  );
endinterface

// File: rtl/nested_addr_counter.sv
// Three-level layer/neuron/input index counter; the input index is innermost.
module nested_addr_counter
  import bitserial_nn_pkg::*;
#(
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  parameter int N_LAYERS = 3,
  parameter int L_W      = addr_w(N_LAYERS),
  parameter int H_W      = addr_w(N_HIDDEN),
  parameter int I_W      = addr_w(N_IN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           clr,
  output logic [L_W-1:0] l,
  output logic [H_W-1:0] h,
  output logic [I_W-1:0] i,
  output logic           at_last
);

  localparam logic [L_W-1:0] L_MAX = L_W'(N_LAYERS - 1);
  localparam logic [H_W-1:0] H_MAX = H_W'(N_HIDDEN - 1);
  localparam logic [I_W-1:0] I_MAX = I_W'(N_IN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l <= '0;
      h <= '0;
      i <= '0;
    end else if (clr) begin
      l <= '0;
      h <= '0;
      i <= '0;
    end else if (inc) begin
      if (i == I_MAX) begin
        i <= '0;
        if (h == H_MAX) begin
          h <= '0;
          l <= (l == L_MAX) ? '0 : l + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end else begin
        i <= i + 1'b1;
      end
    end
  end

  assign at_last = (l == L_MAX) && (h == H_MAX) && (i == I_MAX);

endmodule

// File: rtl/wmem_stream_loader.sv
// Streams one frame of signed weights into the engine's weight memory, one
// registered write per accepted beat, with tlast framing check and done pulse.
module wmem_stream_loader
  import bitserial_nn_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  parameter int N_LAYERS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                busy,
  wmem_stream_loader_if.slave bus,
  output logic                loading,
  output logic                load_done,
  output logic                load_error,
  output loader_state_t       state_dbg
);

  localparam int L_W = addr_w(N_LAYERS);
  localparam int H_W = addr_w(N_HIDDEN);
  localparam int I_W = addr_w(N_IN);

  loader_state_t  state;
  loader_state_t  state_next;
  logic [L_W-1:0] cnt_l;
  logic [H_W-1:0] cnt_h;
  logic [I_W-1:0] cnt_i;
  logic           at_last;
  logic           tready;
  logic           accept;
  logic           cnt_inc;
  logic           cnt_clr;
  logic           err_set;
  logic           err_clr;
  logic           done_set;

  nested_addr_counter #(
    .N_IN     (N_IN),
    .N_HIDDEN (N_HIDDEN),
    .N_LAYERS (N_LAYERS),
    .L_W      (L_W),
    .H_W      (H_W),
    .I_W      (I_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .l       (cnt_l),
    .h       (cnt_h),
    .i       (cnt_i),
    .at_last (at_last)
  );

  assign tready            = (state == LOAD) && !busy;
  assign bus.s_axis_tready = tready;
  assign accept            = bus.s_axis_tvalid && tready;
  assign state_dbg         = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_clr    = 1'b1;
          err_clr    = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_inc = 1'b1;
          // The final beat always completes the frame; a stray tlast aborts it.
          if (at_last) begin
            state_next = DONE;
            err_set    = !bus.s_axis_tlast;
          end else if (bus.s_axis_tlast) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        done_set   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // loading spans LOAD and DONE so it falls exactly when load_done rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.w_wr_en  <= 1'b0;
      bus.w_addr_l <= '0;
      bus.w_addr_h <= '0;
      bus.w_addr_i <= '0;
      bus.w_data   <= '0;
      loading      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      bus.w_wr_en <= accept;
      if (accept) begin
        bus.w_addr_l <= cnt_l;
        bus.w_addr_h <= cnt_h;
        bus.w_addr_i <= cnt_i;
        bus.w_data   <= bus.s_axis_tdata;
      end
      loading   <= (state_next != IDLE);
      load_done <= done_set;
      if (err_clr)      load_error <= 1'b0;
      else if (err_set) load_error <= 1'b1;
    end
  end

endmodule

// File: doc/wmem_stream_loader.md
# wmem_stream_loader

AXI-Stream-to-weight-memory loader for the bit-serial NN engine. Accepts a flat stream of signed weights in layer-major, hidden-major, input-minor order and drives the engine's layer-aware weight write port (`w_wr_en`, `w_addr_l/h/i`, `w_data`) one word per accepted beat. Stalls while the engine is busy, checks frame length against `tlast`, and signals completion, so the host can reload weights between inferences.

## Interface
- `DATA_W`, 16, weight word width
- `N_IN`, 128, inputs per neuron (innermost address)
- `N_HIDDEN`, 64, neurons per layer
- `N_LAYERS`, 3, layer count (outermost address)
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a load.
- `s_axis_tdata` in DATA_W: signed weight word.
- `s_axis_tvalid` in 1: weight word valid.
- `s_axis_tready` out 1: loader can accept a beat.
- `s_axis_tlast` in 1: marks the last weight of the frame.
- `busy` in 1: engine busy; loader must not write.
- `w_wr_en` out 1: weight write strobe.
- `w_addr_l` out clog2(max(N_LAYERS,2)): layer index.
- `w_addr_h` out clog2(max(N_HIDDEN,2)): neuron index.
- `w_addr_i` out clog2(max(N_IN,2)): input index.
- `w_data` out DATA_W: signed weight.
- `loading` out 1: high in LOAD state.
- `load_done` out 1: one-cycle pulse when a frame completes.
- `load_error` out 1: sticky `tlast` mismatch flag; cleared by `start` or `rst`.

## Operation
- Total frame length: TOTAL = N_LAYERS*N_HIDDEN*N_IN beats.
- FSM states:
  - IDLE: `start` -> LOAD; counters cleared; `load_error` cleared.
  - LOAD: an accepted beat is one where `s_axis_tvalid && s_axis_tready`.
    - Each accepted beat advances the nested counters: `i` increments; when `i` wraps from N_IN-1 to 0, `h` increments; when `h` wraps from N_HIDDEN-1 to 0, `l` increments.
    - Accepting the final beat (l=N_LAYERS-1, h=N_HIDDEN-1, i=N_IN-1) -> DONE.
  - DONE: lasts one cycle, pulses `load_done`, then -> IDLE.
- `s_axis_tready` = (state==LOAD) && !busy. This is combinational and does not depend on `tvalid`.
- Each accepted beat writes at the pre-increment address.
- `tlast` check:
  - `tlast` on a non-final beat: that beat is still written, `load_error` is set, and the FSM goes to IDLE with no `load_done`.
  - Final beat without `tlast`: the write happens, `load_error` is set, and `load_done` still pulses.
- `start` in LOAD or DONE is ignored.
- `busy` rising during LOAD: `s_axis_tready` drops in the same cycle and the counters hold. Loading resumes on the first cycle `busy` is low.
- A beat presented while not in LOAD is neither accepted nor written.

## Timing
- Reset values:
  - FSM in IDLE.
  - `w_wr_en`, `loading`, `load_done`, `load_error` are 0.
  - `w_addr_*` and `w_data` are 0.
  - `s_axis_tready` is 0.
- Write latency: the write outputs are registered. A beat accepted at edge N gives `w_wr_en`=1 with its address and data for the cycle after edge N.
- Back-to-back beats produce one write per cycle, so throughput is 1 word/clk.
- `w_wr_en` is never high for more than one cycle per accepted beat.
- `w_addr_*` and `w_data` hold their last values when `w_wr_en`=0.
- `load_done` is high in the cycle after the write strobe for the final word.
- `loading` falls in the same cycle `load_done` rises.
- Asserting `rst` mid-frame immediately does the following, asynchronously:
  - forces IDLE and clears `w_wr_en`;
  - drops `s_axis_tready`;
  - discards the partial frame.
- After `rst`, a new `start` is required.

## Structure
- Shared package `bitserial_nn_pkg`:
  - localparams for the address widths: `WMEM_L_W`, `WMEM_H_W`, `WMEM_I_W`, each with the max(…,2) guard;
  - the `loader_state_t` enum {IDLE, LOAD, DONE}.
- One sub-module, `nested_addr_counter`: a three-level wrap counter.
  - Inputs: `inc`, `clr`.
  - Outputs: `l`, `h`, `i`, and `at_last` (all three indices at their maximum).

## Test plan
Use N_IN=4, N_HIDDEN=2, N_LAYERS=2, so TOTAL=16.
- Full load: `start`, then 16 beats with tdata=0..15 and `tlast` on beat 15, back-to-back.
  - 16 writes on consecutive cycles.
  - Beat 5 writes to (l=0, h=1, i=1); beat 15 writes to (1, 1, 3) with data 15.
  - `load_done` pulses once; `load_error`=0.
- Stall: raise `busy` for 3 cycles after beat 6 is accepted.
  - `s_axis_tready`=0 and no `w_wr_en` during those 3 cycles.
  - Beat 7 then writes to (0, 1, 3).
  - The frame completes correctly.
- Early `tlast` on beat 9:
  - 10 writes total, `load_error`=1, no `load_done`, FSM in IDLE.
  - A later `start` clears `load_error`.
- Missing `tlast` on beat 15: all 16 writes occur, `load_done`=1 and `load_error`=1.
- Reset after beat 4:
  - `w_wr_en`=0 and `s_axis_tready`=0 immediately.
  - After release, `start` plus 16 beats begins again at address (0, 0, 0).
- Idle rejection: `tvalid`=1 with no `start` -> `s_axis_tready`=0 and zero writes over 20 cycles.
